// File: rtl/arbitro_capa_if.sv
// Bus bundle between the fixed-priority arbiter and its input/output FIFOs.
// master = arbiter side, slave = FIFO/environment side.
interface arbitro_capa_if;
    logic        Enable;
    logic [3:0]  fifo_in_empty;
    logic [47:0] fifo_in_data;
    logic [3:0]  fifo_out_almost_full;
    logic [3:0]  pop_in;
    logic [3:0]  push_out;
    logic [11:0] data_out;
    logic        idle;
    logic        req;
    logic [2:0]  idx;
    logic [4:0]  salida_contador;
    logic        valid_contador;

    modport master (
        input  Enable, fifo_in_empty, fifo_in_data, fifo_out_almost_full, req, idx,
        output pop_in, push_out, data_out, idle, salida_contador, valid_contador
    );

    modport slave (
        output Enable, fifo_in_empty, fifo_in_data, fifo_out_almost_full, req, idx,
        input  pop_in, push_out, data_out, idle, salida_contador, valid_contador
    );
endinterface

// File: rtl/arbitro_capa.sv
// Fixed-priority 4x4 FIFO arbiter: combinational pop, registered push one cycle later.
// Optional per-output word counters are compiled in with ARBITRO_CONTADOR_EN.
module arbitro_capa (
    input  logic            clk,
    input  logic            reset,
    arbitro_capa_if.master  bus
);
    localparam int unsigned N_IN  = 4;
    localparam int unsigned W     = 12;
    localparam int unsigned CW    = 5;
    localparam int unsigned N_CNT = 5;

    logic [W-1:0]    word_c [N_IN];
    logic [N_IN-1:0] eligible_c;
    logic [N_IN-1:0] grant_c;
    logic [N_IN-1:0] pop_c;
    logic [W-1:0]    sel_word_c;
    logic            found_c;
    logic [N_IN-1:0] push_q;
    logic [W-1:0]    data_q;

    // An input is eligible only if its destination can still take a word.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            word_c[i]     = bus.fifo_in_data[W*i +: W];
            eligible_c[i] = bus.Enable & ~bus.fifo_in_empty[i]
                          & ~bus.fifo_out_almost_full[word_c[i][W-1 -: 2]];
        end
    end

    // Lowest-numbered eligible input wins.
    always_comb begin
        grant_c    = '0;
        sel_word_c = '0;
        found_c    = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (eligible_c[i] && !found_c) begin
                grant_c[i] = 1'b1;
                sel_word_c = word_c[i];
                found_c    = 1'b1;
            end
        end
    end

    assign pop_c = reset ? '0 : grant_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            push_q <= '0;
            data_q <= '0;
        end else begin
            push_q <= '0;
            if (|pop_c) begin
                push_q[sel_word_c[W-1 -: 2]] <= 1'b1;
                data_q                       <= sel_word_c;
            end
        end
    end

    assign bus.pop_in   = pop_c;
    assign bus.push_out = push_q;
    assign bus.data_out = data_q;
    assign bus.idle     = (&bus.fifo_in_empty) & ~(|pop_c);

`ifdef ARBITRO_CONTADOR_EN
    logic [CW-1:0] cnt_q     [N_CNT];
    logic [CW-1:0] cnt_nxt_c [N_CNT];
    logic [CW-1:0] rd_c;
    logic [CW-1:0] salida_q;
    logic          valid_q;

    // Next counter values; reads see them so a same-cycle push is included.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            cnt_nxt_c[k] = cnt_q[k] + CW'(push_q[k]);
        end
        cnt_nxt_c[N_CNT-1] = cnt_q[N_CNT-1] + CW'(|push_q);
    end

    always_comb begin
        rd_c = '0;
        for (int k = 0; k < N_CNT; k++) begin
            if (bus.idx == 3'(k)) rd_c = cnt_nxt_c[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_CNT; k++) cnt_q[k] <= '0;
            salida_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            for (int k = 0; k < N_CNT; k++) cnt_q[k] <= cnt_nxt_c[k];
            valid_q <= bus.req;
            if (bus.req) salida_q <= rd_c;
        end
    end

    assign bus.salida_contador = salida_q;
    assign bus.valid_contador  = valid_q;
`else
    logic unused_rd;
    assign unused_rd           = ^{bus.req, bus.idx};
    assign bus.salida_contador = '0;
    assign bus.valid_contador  = 1'b0;
`endif
endmodule

// File: tb/tb_arbitro_capa.sv
// Directed bench for arbitro_capa: single-cycle vector table plus multi-cycle sequences.
// Counter checks are compiled when ARBITRO_CONTADOR_EN is defined.
module tb_arbitro_capa;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arbitro_capa_if bus ();

    arbitro_capa dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        en;
        logic [3:0]  empty;
        logic [47:0] data;
        logic [3:0]  afull;
        logic [3:0]  exp_pop;
        logic [3:0]  exp_push;
        logic [11:0] exp_dout;
        logic        exp_idle;
    } vec_t;

    localparam logic [47:0] D0 = {12'h8A3, 12'h8A2, 12'h8A1, 12'h8A0};
    localparam logic [47:0] D1 = {12'h833, 12'h022, 12'hC11, 12'h455};

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs [10];
    logic [11:0] mem [4][4];
    int rd [4];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic en, input logic [3:0] emp, input logic [47:0] dat,
                         input logic [3:0] af);
        bus.Enable               = en;
        bus.fifo_in_empty        = emp;
        bus.fifo_in_data         = dat;
        bus.fifo_out_almost_full = af;
    endtask

    // Drain 4 words per input (one per destination) through the arbiter.
    task automatic run16(input int pass_no);
        logic [47:0] dat;
        logic [3:0]  emp;
        logic [3:0]  exp_pop;
        logic [11:0] w;
        logic [11:0] exp_w;
        int          sel;
        int          seen;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            for (int d = 0; d < 4; d++) mem[i][d] = 12'((d << 10) | (i << 4) | d);
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            emp = '1;
            dat = '0;
            sel = -1;
            for (int i = 0; i < 4; i++) begin
                if (rd[i] < 4) begin
                    emp[i] = 1'b0;
                    w = mem[i][rd[i]];
                    dat[12*i +: 12] = w;
                    if (sel < 0) sel = i;
                end
            end
            if (sel < 0) break;
            exp_pop = '0;
            exp_pop[sel] = 1'b1;
            exp_w = mem[sel][rd[sel]];
            drive(1'b1, emp, dat, 4'b0000);
            #1;
            chk($sformatf("run%0d_pop_c%0d", pass_no, cyc), 48'(bus.pop_in), 48'(exp_pop));
            @(posedge clk); #1;
            chk($sformatf("run%0d_push_c%0d", pass_no, cyc), 48'(bus.push_out),
                48'(4'b0001 << exp_w[11:10]));
            chk($sformatf("run%0d_dout_c%0d", pass_no, cyc), 48'(bus.data_out), 48'(exp_w));
            if (bus.push_out != 4'b0000) seen++;
            rd[sel]++;
        end
        drive(1'b1, 4'b1111, '0, 4'b0000);
        #1;
        chk($sformatf("run%0d_idle", pass_no), 48'(bus.idle), 48'(1));
        @(posedge clk); #1;
        chk($sformatf("run%0d_push_after", pass_no), 48'(bus.push_out), 48'(0));
        chk($sformatf("run%0d_push_count", pass_no), 48'(seen), 48'(16));
    endtask

    task automatic read_cnt(input logic [2:0] k, input logic [4:0] exp_val, input logic exp_vld);
        bus.req = 1'b1;
        bus.idx = k;
        @(posedge clk); #1;
        chk($sformatf("cnt_valid_idx%0d", k), 48'(bus.valid_contador), 48'(exp_vld));
        chk($sformatf("cnt_value_idx%0d", k), 48'(bus.salida_contador), 48'(exp_val));
        bus.req = 1'b0;
        bus.idx = '0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 4'b0000, D0, 4'b0000, 4'b0001, 4'b0100, 12'h8A0, 1'b0};
        vecs[1] = '{1'b1, 4'b0001, D0, 4'b0000, 4'b0010, 4'b0100, 12'h8A1, 1'b0};
        vecs[2] = '{1'b1, 4'b0011, D0, 4'b0000, 4'b0100, 4'b0100, 12'h8A2, 1'b0};
        vecs[3] = '{1'b1, 4'b0111, D0, 4'b0000, 4'b1000, 4'b0100, 12'h8A3, 1'b0};
        vecs[4] = '{1'b1, 4'b1111, D0, 4'b0000, 4'b0000, 4'b0000, 12'h8A3, 1'b1};
        vecs[5] = '{1'b0, 4'b0000, D0, 4'b0000, 4'b0000, 4'b0000, 12'h8A3, 1'b0};
        vecs[6] = '{1'b1, 4'b0000, D1, 4'b0010, 4'b0010, 4'b1000, 12'hC11, 1'b0};
        vecs[7] = '{1'b1, 4'b0000, D1, 4'b1111, 4'b0000, 4'b0000, 12'hC11, 1'b0};
        vecs[8] = '{1'b1, 4'b0000, D1, 4'b1011, 4'b1000, 4'b0100, 12'h833, 1'b0};
        vecs[9] = '{1'b1, 4'b0000, D1, 4'b0000, 4'b0001, 4'b0010, 12'h455, 1'b0};

        bus.req = 1'b0;
        bus.idx = '0;

        // Reset with every input non-empty and eligible.
        reset = 1'b1;
        drive(1'b1, 4'b0000, D0, 4'b0000);
        #1;
        chk("rst_pop_comb", 48'(bus.pop_in), 48'(0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop", 48'(bus.pop_in), 48'(0));
        chk("rst_push", 48'(bus.push_out), 48'(0));
        chk("rst_dout", 48'(bus.data_out), 48'(0));
        chk("rst_idle", 48'(bus.idle), 48'(0));
        chk("rst_valid", 48'(bus.valid_contador), 48'(0));
        chk("rst_salida", 48'(bus.salida_contador), 48'(0));
        reset = 1'b0;

        foreach (vecs[v]) begin
            drive(vecs[v].en, vecs[v].empty, vecs[v].data, vecs[v].afull);
            #1;
            chk($sformatf("vec%0d_pop", v), 48'(bus.pop_in), 48'(vecs[v].exp_pop));
            chk($sformatf("vec%0d_idle", v), 48'(bus.idle), 48'(vecs[v].exp_idle));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_push", v), 48'(bus.push_out), 48'(vecs[v].exp_push));
            chk($sformatf("vec%0d_dout", v), 48'(bus.data_out), 48'(vecs[v].exp_dout));
        end

        // Almost-full release: input0 (dest1) waits until its destination frees up.
        drive(1'b1, 4'b1100, {24'h0, 12'hC11, 12'h455}, 4'b0010);
        #1;
        chk("af_pop_first", 48'(bus.pop_in), 48'(4'b0010));
        @(posedge clk); #1;
        drive(1'b1, 4'b1110, {36'h0, 12'h455}, 4'b0010);
        #1;
        chk("af_pop_blocked", 48'(bus.pop_in), 48'(0));
        @(posedge clk); #1;
        drive(1'b1, 4'b1110, {36'h0, 12'h455}, 4'b0000);
        #1;
        chk("af_pop_release", 48'(bus.pop_in), 48'(4'b0001));
        @(posedge clk); #1;
        chk("af_push_release", 48'(bus.push_out), 48'(4'b0010));
        chk("af_dout_release", 48'(bus.data_out), 48'(12'h455));

        // Enable drops right after a grant: the granted word still lands.
        drive(1'b1, 4'b1110, D0, 4'b0000);
        #1;
        chk("en_pop_grant", 48'(bus.pop_in), 48'(4'b0001));
        @(posedge clk); #1;
        bus.Enable = 1'b0;
        #1;
        chk("en_pop_off", 48'(bus.pop_in), 48'(0));
        chk("en_push_inflight", 48'(bus.push_out), 48'(4'b0100));
        chk("en_dout_inflight", 48'(bus.data_out), 48'(12'h8A0));
        @(posedge clk); #1;
        chk("en_push_off", 48'(bus.push_out), 48'(0));
        chk("en_pop_still_off", 48'(bus.pop_in), 48'(0));
        bus.Enable = 1'b1;
        #1;
        chk("en_pop_resume", 48'(bus.pop_in), 48'(4'b0001));
        @(posedge clk); #1;
        chk("en_push_resume", 48'(bus.push_out), 48'(4'b0100));

        // Reset in a would-be grant cycle: no pop, nothing pushed, data cleared.
        reset = 1'b1;
        drive(1'b1, 4'b0000, D1, 4'b0000);
        #1;
        chk("midrst_pop", 48'(bus.pop_in), 48'(0));
        @(posedge clk); #1;
        chk("midrst_push", 48'(bus.push_out), 48'(0));
        chk("midrst_dout", 48'(bus.data_out), 48'(0));
        reset = 1'b0;

        run16(1);
`ifdef ARBITRO_CONTADOR_EN
        read_cnt(3'd0, 5'd4, 1'b1);
        read_cnt(3'd1, 5'd4, 1'b1);
        read_cnt(3'd2, 5'd4, 1'b1);
        read_cnt(3'd3, 5'd4, 1'b1);
        read_cnt(3'd4, 5'd16, 1'b1);
        read_cnt(3'd5, 5'd0, 1'b1);
        run16(2);
        read_cnt(3'd0, 5'd8, 1'b1);
        read_cnt(3'd1, 5'd8, 1'b1);
        read_cnt(3'd2, 5'd8, 1'b1);
        read_cnt(3'd3, 5'd8, 1'b1);
        read_cnt(3'd4, 5'd0, 1'b1);
        @(posedge clk); #1;
        chk("cnt_valid_idle", 48'(bus.valid_contador), 48'(0));
`else
        read_cnt(3'd4, 5'd0, 1'b0);
        read_cnt(3'd0, 5'd0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/arbitro_capa.md
ARBITRO_CAPA -- requirements
Module: arbitro_capa

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Enable, input, 1 bit: arbitration allowed when high (driven by the init/idle FSM).
REQ-004 SHALL have port fifo_in_empty, input, 4 bits: empty flag of input FIFOs 0..3.
REQ-005 SHALL have port fifo_in_data, input, 48 bits: head word of input FIFO i on bits [12i+11:12i] (show-ahead).
REQ-006 SHALL have port fifo_out_almost_full, input, 4 bits: almost-full flag of output FIFOs 0..3.
REQ-007 SHALL have port pop_in, output, 4 bits: one-hot pop to input FIFOs.
REQ-008 SHALL have port push_out, output, 4 bits: one-hot push to output FIFOs.
REQ-009 SHALL have port data_out, output, 12 bits: word driven to all output FIFOs.
REQ-010 SHALL have port idle, output, 1 bit: no work pending.
REQ-011 SHALL have port req, input, 1 bit: counter read request.
REQ-012 SHALL have port idx, input, 3 bits: counter index 0..4.
REQ-013 SHALL have port salida_contador, output, 5 bits: counter read value.
REQ-014 SHALL have port valid_contador, output, 1 bit: salida_contador valid.

Function
REQ-015 SHALL take the destination output FIFO from word bits [11:10].
REQ-016 SHALL treat input i as eligible when Enable=1, fifo_in_empty[i]=0 and fifo_out_almost_full[dest(i)]=0.
REQ-017 SHALL grant the lowest-numbered eligible input, fixed priority 0>1>2>3; an ineligible higher-priority input SHALL NOT block lower ones.
REQ-018 SHALL assert pop_in[g] combinationally in the grant cycle N; at most one pop bit per cycle.
REQ-019 SHALL register the popped word: push_out[dest] high and data_out = word in cycle N+1, exactly one push per pop, latency 1.
REQ-020 SHALL allow back-to-back grants every cycle (throughput 1 word/cycle).
REQ-021 SHALL hold push_out=0 and data_out at its last value in cycles with no grant in N-1.
REQ-022 SHALL on Enable falling stop new pops immediately; a push already registered SHALL still complete.
REQ-023 SHALL drive idle=1 when all fifo_in_empty=1 and no push is pending for the next cycle.
REQ-024 SHALL pop nothing when all eligible flags are 0 (all empty or all destinations almost full).

Reset
REQ-025 SHALL, while reset=1 at a clock edge, set pop_in=0, push_out=0, data_out=0, valid_contador=0, salida_contador=0, all counters 0; pop_in SHALL be 0 during reset regardless of inputs.
REQ-026 SHALL discard a word popped in the cycle reset is asserted (no push follows).

Configuration
REQ-027 SHALL compile per-output word counters only when ARBITRO_CONTADOR_EN is defined.
REQ-028 With ARBITRO_CONTADOR_EN: counter k (0..3) SHALL increment on push_out[k], 5-bit wrap 31->0; counter 4 SHALL increment on any push (equals sum mod 32).
REQ-029 With ARBITRO_CONTADOR_EN: on req=1 in cycle N, salida_contador = counter[idx] and valid_contador=1 in cycle N+1; idx 5..7 SHALL return 0 with valid 1; a push in cycle N SHALL be included in the read.
REQ-030 Without ARBITRO_CONTADOR_EN: ports SHALL remain, salida_contador=0 and valid_contador=0 constantly.

Verification
REQ-031 Reset: assert reset 2 cycles with all FIFOs non-empty -> pop_in=0, push_out=0, data_out=0, idle per REQ-023.
REQ-032 Priority: inputs 0..3 each hold word with dest 2 (12'h8A0..8A3), Enable=1 -> pops 0,1,2,3 in 4 consecutive cycles, push_out=4'b0100 with 8A0..8A3 one cycle later each.
REQ-033 Almost full: input0 word dest1, fifo_out_almost_full=4'b0010, input1 word dest3 -> input1 popped first; input0 popped cycle after almost_full drops.
REQ-034 16-combination: 4 words per input, one per destination -> 16 pushes, each word on push_out[word[11:10]], input order per priority, idle=1 after last push.
REQ-035 Counters (ARBITRO_CONTADOR_EN): after REQ-034 read idx 0..4 -> 4,4,4,4,16; repeat -> 8,8,8,8,0 (wrap).
REQ-036 Enable drop: deassert Enable in grant cycle -> that word still pushed next cycle, no further pops until Enable=1.
